// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Time-multiplexes up to eight BCD digit sources onto one 7-segment decoder
// path. Enabled digits are visited in ascending order. Each slot lasts
// 2^PRESC_W cycles, and the first BLANK_CYC cycles of a slot are a dark guard
// interval that prevents ghosting.
//
// Optional feature macro: DISPLAY_BLINK_EN. When it is defined, a 6-bit frame
// counter is added. Digits flagged in blink_mask are dark while bit 5 of that
// counter is set.
//
// Ports:
//   clock        in   single clock
//   reset        in   asynchronous, active-high reset
//   digit_data   in   4*DIGITS  BCD nibble per digit, digit i at [4i+3:4i]
//   digit_en     in   DIGITS    per-digit enable mask
//   dp_in        in   DIGITS    per-digit decimal-point request
//   blink_mask   in   DIGITS    per-digit blink request (blink build only)
//   bytee        out  4         nibble to the decoder
//   byte_status  out  3         binary index of the active digit
//   digit_on     out  1         digit drive enable
//   dp_out       out  1         decimal point of the active digit
//   frame_start  out  1         one-cycle pulse when the lowest enabled digit lights
module display_scan_ctrl #(
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned PRESC_W   = 10,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digit_data,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [3:0]            bytee,
    output logic [2:0]            byte_status,
    output logic                  digit_on,
    output logic                  dp_out,
    output logic                  frame_start
);

    localparam int unsigned         IDX_W      = 3;
    localparam logic [PRESC_W-1:0]  BLANK_LAST = PRESC_W'(BLANK_CYC - 1);
    localparam logic [PRESC_W-1:0]  SLOT_LAST  = '1;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t             state, state_nxt;
    logic [PRESC_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [3:0]         bytee_nxt;
    logic [2:0]         byte_status_nxt;
    logic               digit_on_nxt;
    logic               dp_out_nxt;
    logic               frame_start_nxt;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   low_idx;
    logic               fs_hit;

`ifdef DISPLAY_BLINK_EN
    logic [5:0]         frame_cnt, frame_cnt_nxt;
`else
    logic               unused_blink;
    assign unused_blink = ^blink_mask;
`endif

    // Lowest set bit of the enable mask (0 when the mask is empty).
    function automatic logic [IDX_W-1:0] lowest_en(input logic [DIGITS-1:0] en);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            if (en[k]) r = IDX_W'(k);
        end
        return r;
    endfunction

    // Next enabled digit above cur, wrapping; returns cur if it is the only one.
    function automatic logic [IDX_W-1:0] next_en(input logic [IDX_W-1:0]  cur,
                                                 input logic [DIGITS-1:0] en);
        logic [IDX_W-1:0] r;
        logic             found;
        int               j;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= int'(DIGITS); k++) begin
            j = (int'(cur) + k) % int'(DIGITS);
            if (!found && en[j]) begin
                r     = IDX_W'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic bit_of(input logic [DIGITS-1:0] vec,
                                    input logic [IDX_W-1:0]  i);
        logic r;
        r = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (IDX_W'(k) == i) r = vec[k];
        end
        return r;
    endfunction

    function automatic logic [3:0] nib_of(input logic [4*DIGITS-1:0] data,
                                          input logic [IDX_W-1:0]    i);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (IDX_W'(k) == i) r = data[4*k +: 4];
        end
        return r;
    endfunction

    // Slot selection: a digit disabled while waiting in BLANK is replaced by the next one.
    always_comb begin
        low_idx = lowest_en(digit_en);
        sel     = digit_en[idx] ? idx : next_en(idx, digit_en);
        fs_hit  = (sel == low_idx);
    end

    // State register and all output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            bytee       <= '0;
            byte_status <= '0;
            digit_on    <= 1'b0;
            dp_out      <= 1'b0;
            frame_start <= 1'b0;
`ifdef DISPLAY_BLINK_EN
            frame_cnt   <= '0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            bytee       <= bytee_nxt;
            byte_status <= byte_status_nxt;
            digit_on    <= digit_on_nxt;
            dp_out      <= dp_out_nxt;
            frame_start <= frame_start_nxt;
`ifdef DISPLAY_BLINK_EN
            frame_cnt   <= frame_cnt_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        idx_nxt         = idx;
        bytee_nxt       = bytee;
        byte_status_nxt = byte_status;
        digit_on_nxt    = digit_on;
        dp_out_nxt      = dp_out;
        frame_start_nxt = 1'b0;
`ifdef DISPLAY_BLINK_EN
        frame_cnt_nxt   = frame_cnt;
`endif

        if (digit_en == '0) begin
            // Nothing to show: park in IDLE and keep the last nibble and index.
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            digit_on_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idx_nxt      = low_idx;
                    cnt_nxt      = '0;
                    digit_on_nxt = 1'b0;
                    state_nxt    = BLANK;
                end

                BLANK: begin
                    idx_nxt      = sel;
                    digit_on_nxt = 1'b0;
                    cnt_nxt      = cnt + PRESC_W'(1);
                    if (cnt == BLANK_LAST) begin
                        // Latch the slot contents; they are frozen until the next slot.
                        state_nxt       = SHOW;
                        byte_status_nxt = sel;
                        bytee_nxt       = nib_of(digit_data, sel);
                        dp_out_nxt      = bit_of(dp_in, sel);
                        frame_start_nxt = fs_hit;
`ifdef DISPLAY_BLINK_EN
                        frame_cnt_nxt   = frame_cnt + 6'(fs_hit);
                        digit_on_nxt    = !(bit_of(blink_mask, sel) && frame_cnt_nxt[5]);
`else
                        digit_on_nxt    = 1'b1;
`endif
                    end
                end

                SHOW: begin
                    if (!digit_en[idx]) begin
                        // Active digit withdrawn: abandon the slot and restart blanking.
                        state_nxt    = BLANK;
                        cnt_nxt      = '0;
                        digit_on_nxt = 1'b0;
                        idx_nxt      = next_en(idx, digit_en);
                    end else if (cnt == SLOT_LAST) begin
                        state_nxt    = BLANK;
                        cnt_nxt      = '0;
                        digit_on_nxt = 1'b0;
                        idx_nxt      = next_en(idx, digit_en);
                    end else begin
                        cnt_nxt = cnt + PRESC_W'(1);
                    end
                end

                default: begin
                    state_nxt    = IDLE;
                    cnt_nxt      = '0;
                    digit_on_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (DIGITS=6, PRESC_W=4, BLANK_CYC=2).
// Expected slot contents are queued when stimulus is applied and compared when
// digit_on rises.
module tb_display_scan_ctrl;

    localparam int unsigned DIGITS    = 6;
    localparam int unsigned PRESC_W   = 4;
    localparam int unsigned BLANK_CYC = 2;

    logic                 clock;
    logic                 reset;
    logic [4*DIGITS-1:0]  digit_data;
    logic [DIGITS-1:0]    digit_en;
    logic [DIGITS-1:0]    dp_in;
    logic [DIGITS-1:0]    blink_mask;
    logic [3:0]           bytee;
    logic [2:0]           byte_status;
    logic                 digit_on;
    logic                 dp_out;
    logic                 frame_start;

    typedef struct packed {
        logic [2:0] idx;
        logic [3:0] nib;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   last_rise = 0;

    display_scan_ctrl #(
        .DIGITS    (DIGITS),
        .PRESC_W   (PRESC_W),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .digit_data  (digit_data),
        .digit_en    (digit_en),
        .dp_in       (dp_in),
        .blink_mask  (blink_mask),
        .bytee       (bytee),
        .byte_status (byte_status),
        .digit_on    (digit_on),
        .dp_out      (dp_out),
        .frame_start (frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic fs);
        exp_t e;
        logic [4*DIGITS-1:0] d;
        d     = digit_data;
        e.idx = 3'(i);
        e.nib = d[4*i +: 4];
        e.dp  = dp_in[i];
        e.fs  = fs;
        sb.push_back(e);
    endtask

    // Wait (bounded) for digit_on to be low and then rise.
    task automatic wait_rise(output int ok);
        int   n;
        logic low_seen;
        n = 0;
        while (digit_on !== 1'b0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        low_seen = (digit_on === 1'b0);
        n = 0;
        while (digit_on !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        ok = (low_seen && digit_on === 1'b1) ? 1 : 0;
    endtask

    task automatic wait_slot(input string tag, input int exp_period);
        int   ok;
        exp_t e;
        wait_rise(ok);
        check({tag, "_rise"}, 32'(ok), 32'd1);
        if (exp_period >= 0) check({tag, "_period"}, 32'(cyc - last_rise), 32'(exp_period));
        last_rise = cyc;
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_byte_status"}, 32'(byte_status), 32'(e.idx));
            check({tag, "_bytee"},       32'(bytee),       32'(e.nib));
            check({tag, "_dp_out"},      32'(dp_out),      32'(e.dp));
            check({tag, "_frame_start"}, 32'(frame_start), 32'(e.fs));
        end
    endtask

    initial begin
        int ok;
        int hi;
        int n;
        int bad;
        int c0;

        reset      = 1'b1;
        digit_en   = '0;
        digit_data = 24'h123456;
        dp_in      = 6'b000101;
        blink_mask = '0;
        repeat (2) @(negedge clock);

        // Get into SHOW of digit 0, then hit reset asynchronously mid-slot.
        digit_en = 6'h3F;
        reset    = 1'b0;
        wait_rise(ok);
        check("pre_rise", 32'(ok), 32'd1);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_digit_on",    32'(digit_on),    32'd0);
        check("rst_bytee",       32'(bytee),       32'd0);
        check("rst_byte_status", 32'(byte_status), 32'd0);
        check("rst_dp_out",      32'(dp_out),      32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);

        // Test 1: release; digit_on rises on the third edge and stays 14 cycles.
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t1_e1_on", 32'(digit_on), 32'd0);
        @(negedge clock);
        check("t1_e2_on", 32'(digit_on), 32'd0);
        @(negedge clock);
        check("t1_e3_on",          32'(digit_on),    32'd1);
        check("t1_e3_byte_status", 32'(byte_status), 32'd0);
        check("t1_e3_bytee",       32'(bytee),       32'd6);
        check("t1_e3_frame_start", 32'(frame_start), 32'd1);
        check("t1_e3_dp_out",      32'(dp_out),      32'd1);
        last_rise = cyc;
        hi = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (k == 0) check("t1_fs_pulse", 32'(frame_start), 32'd0);
            if (digit_on !== 1'b1) break;
            hi++;
        end
        check("t1_on_len", 32'(hi), 32'd14);

        // Test 2: skipping disabled digits, 0/2/5 cycle at 16-cycle slots.
        digit_en = 6'b100101;
        push(2, 1'b0); push(5, 1'b0); push(0, 1'b1);
        push(2, 1'b0); push(5, 1'b0); push(0, 1'b1);
        repeat (6) wait_slot("t2", 16);

        // Test 3: all digits disabled mid-SHOW, then a single digit.
        repeat (5) @(negedge clock);
        digit_en = '0;
        @(negedge clock);
        check("t3_off",         32'(digit_on),    32'd0);
        check("t3_hold_bytee",  32'(bytee),       32'd6);
        check("t3_hold_status", 32'(byte_status), 32'd0);
        bad = 0;
        repeat (12) begin
            @(negedge clock);
            if (digit_on !== 1'b0) bad++;
        end
        check("t3_idle_dark",   32'(bad),   32'd0);
        check("t3_idle_bytee",  32'(bytee), 32'd6);
        digit_en = 6'b001000;
        c0 = cyc;
        push(3, 1'b1); push(3, 1'b1); push(3, 1'b1);
        wait_slot("t3a", -1);
        check("t3_latency", 32'(last_rise - c0), 32'd3);
        wait_slot("t3b", 16);
        wait_slot("t3c", 16);

        // Test 4: digit 0 nibble changes while it is being shown.
        digit_en = 6'h3F;
        push(4, 1'b0); push(5, 1'b0); push(0, 1'b1);
        repeat (3) wait_slot("t4a", 16);
        repeat (3) @(negedge clock);
        digit_data[3:0] = 4'h9;
        bad = 0;
        n   = 0;
        while (digit_on === 1'b1 && n < 20) begin
            if (bytee !== 4'd6) bad++;
            @(negedge clock);
            n++;
        end
        check("t4_no_tear",     32'(bad), 32'd0);
        check("t4_held_cycles", 32'(n),   32'd11);
        push(1, 1'b0); push(2, 1'b0); push(3, 1'b0);
        push(4, 1'b0); push(5, 1'b0); push(0, 1'b1);
        push(1, 1'b0);
        repeat (7) wait_slot("t4b", 16);

        // Test 5: active digit 1 disabled during its SHOW.
        repeat (3) @(negedge clock);
        digit_en = 6'b111101;
        @(negedge clock);
        check("t5_off", 32'(digit_on), 32'd0);
        c0 = cyc;
        push(2, 1'b0);
        wait_slot("t5a", -1);
        check("t5_gap", 32'(last_rise - c0), 32'd2);
        push(3, 1'b0);
        wait_slot("t5b", 16);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
